// File: rtl/trace_decoder_v12_pkg.sv
// Shared types and constants for the trace record decoder.
// Contents: record layout (trace_record_v12_t), version/size codes, sequence
// FSM states, S1 payload, decoded event payload, saturating increment helper.
package trace_pkg_v12;

   localparam int unsigned REC_W  = 512;
   localparam int unsigned SIZE_W = 7;
   localparam int unsigned CNT_W  = 32;

   localparam logic [7:0]        TRACE_VER_V11  = 8'h01;
   localparam logic [7:0]        TRACE_VER_V12  = 8'h02;
   localparam logic [SIZE_W-1:0] TRACE_SIZE_V11 = 7'd48;
   localparam logic [SIZE_W-1:0] TRACE_SIZE_V12 = 7'd64;

   typedef enum logic [7:0] {
      REC_NONE     = 8'h00,
      REC_TX_EVENT = 8'h01,
      REC_MARKER   = 8'h02
   } rec_type_t;

   typedef enum logic {
      SEQ_INIT   = 1'b0,
      SEQ_LOCKED = 1'b1
   } seq_state_t;

   typedef struct packed {
      logic [14:0] rsvd;
      logic        valid;
   } trace_flags_t;

   // Byte 0 sits at bits [7:0]; a v1.1 record occupies bytes 0..47, the
   // v1.2 attribution words live in bytes 48..63.
   typedef struct packed {
      logic [31:0]  d_egress;
      logic [31:0]  d_risk;
      logic [31:0]  d_core;
      logic [31:0]  d_ingress;
      logic [127:0] rsvd1;
      logic [63:0]  t_egress;
      logic [63:0]  t_ingress;
      logic [31:0]  rsvd0;
      logic [31:0]  seq_no;
      logic [15:0]  tx_id;
      logic [15:0]  core_id;
      trace_flags_t flags;
      logic [7:0]   record_type;
      logic [7:0]   version;
   } trace_record_v12_t;

   // Fields held by S1 for a good record (d_* already zeroed for v1.1).
   typedef struct packed {
      logic [31:0] seq_no;
      logic [15:0] tx_id;
      logic [15:0] core_id;
      logic [63:0] t_ingress;
      logic [63:0] t_egress;
      logic [31:0] d_ingress;
      logic [31:0] d_core;
      logic [31:0] d_risk;
      logic [31:0] d_egress;
      logic        has_attr;
      logic        gap;
   } s1_rec_t;

   typedef struct packed {
      logic [31:0] seq_no;
      logic [15:0] tx_id;
      logic [15:0] core_id;
      logic [63:0] latency;
      logic [31:0] d_ingress;
      logic [31:0] d_core;
      logic [31:0] d_risk;
      logic [31:0] d_egress;
      logic [63:0] residual;
      logic        has_attr;
      logic        attr_over;
      logic        gap;
   } decoded_event_t;

   function automatic logic [CNT_W-1:0] sat_inc32(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/trace_decoder_v12_if.sv
// Record input stream and decoded event output stream of the trace decoder.
// master: record source / event sink side.  slave: the decoder.
interface trace_decoder_v12_if;
   import trace_pkg_v12::*;

   logic               in_valid;
   logic               in_ready;
   logic [REC_W-1:0]   in_data;
   logic [SIZE_W-1:0]  in_size;

   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_seq_no;
   logic [15:0]        out_tx_id;
   logic [15:0]        out_core_id;
   logic [63:0]        out_latency;
   logic [31:0]        out_d_ingress;
   logic [31:0]        out_d_core;
   logic [31:0]        out_d_risk;
   logic [31:0]        out_d_egress;
   logic [63:0]        out_residual;
   logic               out_has_attr;
   logic               out_attr_over;
   logic               out_gap;

   modport master (
      output in_valid, in_data, in_size, out_ready,
      input  in_ready, out_valid, out_seq_no, out_tx_id, out_core_id,
             out_latency, out_d_ingress, out_d_core, out_d_risk, out_d_egress,
             out_residual, out_has_attr, out_attr_over, out_gap
   );

   modport slave (
      input  in_valid, in_data, in_size, out_ready,
      output in_ready, out_valid, out_seq_no, out_tx_id, out_core_id,
             out_latency, out_d_ingress, out_d_core, out_d_risk, out_d_egress,
             out_residual, out_has_attr, out_attr_over, out_gap
   );

endinterface

// File: rtl/trace_decoder_v12_seq_tracker.sv
// Sequence-number continuity tracker (instantiated as trace_seq_tracker).
// Ports: clk, rst (async, active-high); i_strobe (good record accepted),
// i_seq_no, i_stats_clr in; o_gap_c (gap flag for the record on i_seq_no,
// combinational), o_gap_count, o_reorder_count out (registered, saturating).
module trace_seq_tracker
   import trace_pkg_v12::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_strobe,
   input  logic [31:0]      i_seq_no,
   input  logic             i_stats_clr,
   output logic             o_gap_c,
   output logic [CNT_W-1:0] o_gap_count,
   output logic [CNT_W-1:0] o_reorder_count
);

   seq_state_t       r_state, w_next_state;
   logic [31:0]      r_expected, w_next_expected;
   logic [CNT_W-1:0] r_gap_count, w_next_gap_count;
   logic [CNT_W-1:0] r_reorder_count, w_next_reorder_count;
   logic [31:0]      w_diff;
   logic [CNT_W:0]   w_gap_sum;

   // diff[31] set means the record is at or behind what was already seen.
   assign w_diff    = i_seq_no - r_expected;
   assign w_gap_sum = (CNT_W+1)'(r_gap_count) + (CNT_W+1)'(w_diff);

   // Next-state, expected seq, counters and gap flag.
   always_comb begin
      w_next_state         = r_state;
      w_next_expected      = r_expected;
      w_next_gap_count     = r_gap_count;
      w_next_reorder_count = r_reorder_count;
      o_gap_c              = 1'b0;

      case (r_state)
         SEQ_INIT: begin
            if (i_strobe) begin
               w_next_expected = i_seq_no + 32'd1;
               w_next_state    = SEQ_LOCKED;
            end
         end
         SEQ_LOCKED: begin
            if (i_strobe) begin
               if (w_diff == 32'd0) begin
                  w_next_expected = i_seq_no + 32'd1;
               end else if (!w_diff[31]) begin
                  o_gap_c          = 1'b1;
                  w_next_gap_count = w_gap_sum[CNT_W] ? {CNT_W{1'b1}}
                                                      : w_gap_sum[CNT_W-1:0];
                  w_next_expected  = i_seq_no + 32'd1;
               end else begin
                  w_next_reorder_count = sat_inc32(r_reorder_count);
               end
            end
         end
         default: w_next_state = SEQ_INIT;
      endcase

      // Clear overrides any same-cycle update.
      if (i_stats_clr) begin
         w_next_state         = SEQ_INIT;
         w_next_gap_count     = '0;
         w_next_reorder_count = '0;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= SEQ_INIT;
         r_expected      <= '0;
         r_gap_count     <= '0;
         r_reorder_count <= '0;
      end else begin
         r_state         <= w_next_state;
         r_expected      <= w_next_expected;
         r_gap_count     <= w_next_gap_count;
         r_reorder_count <= w_next_reorder_count;
      end
   end

   assign o_gap_count     = r_gap_count;
   assign o_reorder_count = r_reorder_count;

endmodule

// File: rtl/trace_decoder_v12.sv
// Trace record decoder: validates 48B/64B trace records, tracks sequence
// continuity and emits one decoded latency/attribution event per good record.
// Ports: clk, rst (async, active-high); bus (record in / event out streams);
// stats_clr (sync counter clear); rec_count, err_count, gap_count,
// reorder_count (saturating status counters).
module trace_decoder_v12
   import trace_pkg_v12::*;
#(
   parameter bit          ACCEPT_V11    = 1'b1,
   parameter bit          CHECK_CORE_ID = 1'b0,
   parameter logic [15:0] CORE_ID       = 16'h0000
) (
   input  logic                clk,
   input  logic                rst,
   trace_decoder_v12_if.slave  bus,
   input  logic                stats_clr,
   output logic [CNT_W-1:0]    rec_count,
   output logic [CNT_W-1:0]    err_count,
   output logic [CNT_W-1:0]    gap_count,
   output logic [CNT_W-1:0]    reorder_count
);

   trace_record_v12_t w_rec;
   logic              w_is_v12, w_is_v11, w_good;
   logic              w_s2_load, w_in_ready, w_accept;
   logic              w_good_accept, w_bad_accept;
   logic              w_gap;
   s1_rec_t           w_s1_next;
   logic              w_unused;

   logic              r_s1_valid;
   s1_rec_t           r_s1;
   logic              r_out_valid;
   decoded_event_t    r_out;
   logic [CNT_W-1:0]  r_rec_count, r_err_count;

   logic [63:0]       w_latency;
   logic [33:0]       w_attr_sum;
   logic [63:0]       w_attr_sum64;
   decoded_event_t    w_event;

   assign w_rec    = trace_record_v12_t'(bus.in_data);
   assign w_unused = ^{w_rec.rsvd0, w_rec.rsvd1, w_rec.flags.rsvd};

   // Header classification.
   assign w_is_v12 = (w_rec.version == TRACE_VER_V12) && (bus.in_size == TRACE_SIZE_V12);
   assign w_is_v11 = ACCEPT_V11 && (w_rec.version == TRACE_VER_V11)
                     && (bus.in_size == TRACE_SIZE_V11);
   assign w_good   = (w_is_v12 || w_is_v11)
                     && (w_rec.record_type == REC_TX_EVENT)
                     && w_rec.flags.valid
                     && (!CHECK_CORE_ID || (w_rec.core_id == CORE_ID));

   // Handshake: S2 loads when empty or drained; S1 moves whenever S2 loads.
   assign w_s2_load     = !r_out_valid || bus.out_ready;
   assign w_in_ready    = !r_s1_valid || w_s2_load;
   assign w_accept      = bus.in_valid && w_in_ready;
   assign w_good_accept = w_accept && w_good;
   assign w_bad_accept  = w_accept && !w_good;
   assign bus.in_ready  = w_in_ready;

   trace_seq_tracker u_seq (
      .clk             (clk),
      .rst             (rst),
      .i_strobe        (w_good_accept),
      .i_seq_no        (w_rec.seq_no),
      .i_stats_clr     (stats_clr),
      .o_gap_c         (w_gap),
      .o_gap_count     (gap_count),
      .o_reorder_count (reorder_count)
   );

   // S1 payload; v1.1 records carry no attribution, whatever the upper bytes hold.
   always_comb begin
      w_s1_next           = '0;
      w_s1_next.seq_no    = w_rec.seq_no;
      w_s1_next.tx_id     = w_rec.tx_id;
      w_s1_next.core_id   = w_rec.core_id;
      w_s1_next.t_ingress = w_rec.t_ingress;
      w_s1_next.t_egress  = w_rec.t_egress;
      w_s1_next.has_attr  = w_is_v12;
      w_s1_next.gap       = w_gap;
      if (w_is_v12) begin
         w_s1_next.d_ingress = w_rec.d_ingress;
         w_s1_next.d_core    = w_rec.d_core;
         w_s1_next.d_risk    = w_rec.d_risk;
         w_s1_next.d_egress  = w_rec.d_egress;
      end
   end

   // S1 register: bad records leave S1 empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (w_in_ready) begin
         r_s1_valid <= w_good_accept;
         if (w_good_accept) begin
            r_s1 <= w_s1_next;
         end
      end
   end

   // S2 arithmetic.
   assign w_latency    = r_s1.t_egress - r_s1.t_ingress;
   assign w_attr_sum   = 34'(r_s1.d_ingress) + 34'(r_s1.d_core)
                       + 34'(r_s1.d_risk) + 34'(r_s1.d_egress);
   assign w_attr_sum64 = 64'(w_attr_sum);

   always_comb begin
      w_event           = '0;
      w_event.seq_no    = r_s1.seq_no;
      w_event.tx_id     = r_s1.tx_id;
      w_event.core_id   = r_s1.core_id;
      w_event.latency   = w_latency;
      w_event.d_ingress = r_s1.d_ingress;
      w_event.d_core    = r_s1.d_core;
      w_event.d_risk    = r_s1.d_risk;
      w_event.d_egress  = r_s1.d_egress;
      w_event.residual  = w_latency - w_attr_sum64;
      w_event.has_attr  = r_s1.has_attr;
      w_event.attr_over = (w_attr_sum64 > w_latency);
      w_event.gap       = r_s1.gap;
   end

   // S2 output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else if (w_s2_load) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out <= w_event;
         end
      end
   end

   // Record/error counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rec_count <= '0;
         r_err_count <= '0;
      end else if (stats_clr) begin
         r_rec_count <= '0;
         r_err_count <= '0;
      end else begin
         if (w_good_accept) r_rec_count <= sat_inc32(r_rec_count);
         if (w_bad_accept)  r_err_count <= sat_inc32(r_err_count);
      end
   end

   assign rec_count = r_rec_count;
   assign err_count = r_err_count;

   assign bus.out_valid     = r_out_valid;
   assign bus.out_seq_no    = r_out.seq_no;
   assign bus.out_tx_id     = r_out.tx_id;
   assign bus.out_core_id   = r_out.core_id;
   assign bus.out_latency   = r_out.latency;
   assign bus.out_d_ingress = r_out.d_ingress;
   assign bus.out_d_core    = r_out.d_core;
   assign bus.out_d_risk    = r_out.d_risk;
   assign bus.out_d_egress  = r_out.d_egress;
   assign bus.out_residual  = r_out.residual;
   assign bus.out_has_attr  = r_out.has_attr;
   assign bus.out_attr_over = r_out.attr_over;
   assign bus.out_gap       = r_out.gap;

endmodule

// File: tb/tb_trace_decoder_v12.sv
// Scoreboard bench for trace_decoder_v12: stimulus pushes expected events,
// a negedge monitor pops and compares every accepted output event.
module tb_trace_decoder_v12;
   import trace_pkg_v12::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stats_clr;
   logic [31:0] rec_count, err_count, gap_count, reorder_count;

   trace_decoder_v12_if tif ();

   trace_decoder_v12 #(
      .ACCEPT_V11    (1'b1),
      .CHECK_CORE_ID (1'b0),
      .CORE_ID       (16'h0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (tif),
      .stats_clr     (stats_clr),
      .rec_count     (rec_count),
      .err_count     (err_count),
      .gap_count     (gap_count),
      .reorder_count (reorder_count)
   );

   always #5 clk = ~clk;

   int             n_vec  = 0;
   int             n_miss = 0;
   bit             stall_seen;
   decoded_event_t exp_q[$];

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic trace_record_v12_t mk(
      input logic [7:0] ver, input logic [7:0] rtype, input logic vflag,
      input logic [31:0] seq, input logic [63:0] t_in, input logic [63:0] t_eg,
      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
      trace_record_v12_t r;
      r             = '0;
      r.version     = ver;
      r.record_type = rtype;
      r.flags.valid = vflag;
      r.core_id     = 16'h00C5;
      r.tx_id       = 16'hA000 + 16'(seq);
      r.seq_no      = seq;
      r.t_ingress   = t_in;
      r.t_egress    = t_eg;
      r.d_ingress   = d0;
      r.d_core      = d1;
      r.d_risk      = d2;
      r.d_egress    = d3;
      return r;
   endfunction

   // Reference event for a good record; the gap flag is supplied by the caller.
   function automatic decoded_event_t model(input trace_record_v12_t r, input logic gap);
      decoded_event_t e;
      logic [63:0]    sum;
      logic           v12;
      v12         = (r.version == TRACE_VER_V12);
      e           = '0;
      e.seq_no    = r.seq_no;
      e.tx_id     = r.tx_id;
      e.core_id   = r.core_id;
      e.latency   = r.t_egress - r.t_ingress;
      e.d_ingress = v12 ? r.d_ingress : 32'd0;
      e.d_core    = v12 ? r.d_core    : 32'd0;
      e.d_risk    = v12 ? r.d_risk    : 32'd0;
      e.d_egress  = v12 ? r.d_egress  : 32'd0;
      sum         = 64'(e.d_ingress) + 64'(e.d_core) + 64'(e.d_risk) + 64'(e.d_egress);
      e.residual  = e.latency - sum;
      e.has_attr  = v12;
      e.attr_over = (sum > e.latency);
      e.gap       = gap;
      return e;
   endfunction

   task automatic send(input trace_record_v12_t r, input logic [6:0] sz,
                       input bit good, input logic gap);
      bit acc;
      acc          = 1'b0;
      tif.in_valid = 1'b1;
      tif.in_data  = r;
      tif.in_size  = sz;
      if (good) exp_q.push_back(model(r, gap));
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (tif.in_ready) begin
            acc = 1'b1;
            break;
         end
         stall_seen = 1'b1;
      end
      if (!acc) begin
         n_vec++;
         n_miss++;
         $display("FAIL accept_timeout: seq %h never accepted", r.seq_no);
      end
      @(posedge clk);
      #1;
      tif.in_valid = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_stats();
      stats_clr = 1'b1;
      @(posedge clk);
      #1;
      stats_clr = 1'b0;
   endtask

   function automatic decoded_event_t cur_event();
      decoded_event_t a;
      a.seq_no    = tif.out_seq_no;
      a.tx_id     = tif.out_tx_id;
      a.core_id   = tif.out_core_id;
      a.latency   = tif.out_latency;
      a.d_ingress = tif.out_d_ingress;
      a.d_core    = tif.out_d_core;
      a.d_risk    = tif.out_d_risk;
      a.d_egress  = tif.out_d_egress;
      a.residual  = tif.out_residual;
      a.has_attr  = tif.out_has_attr;
      a.attr_over = tif.out_attr_over;
      a.gap       = tif.out_gap;
      return a;
   endfunction

   // Monitor: pop on every handshake, and check outputs hold while stalled.
   initial begin
      decoded_event_t act, e, prev;
      bit             have_prev;
      have_prev = 1'b0;
      prev      = '0;
      forever begin
         @(negedge clk);
         if (!rst && tif.out_valid) begin
            act = cur_event();
            if (tif.out_ready) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_miss++;
                  $display("FAIL unexpected_event: got seq %h, none expected", act.seq_no);
               end else begin
                  e = exp_q.pop_front();
                  n_vec++;
                  if (act !== e) begin
                     n_miss++;
                     $display("FAIL event_seq_%h: got %h expected %h", e.seq_no, act, e);
                  end
               end
               have_prev = 1'b0;
            end else begin
               if (have_prev) begin
                  n_vec++;
                  if (act !== prev) begin
                     n_miss++;
                     $display("FAIL hold_stable: got %h expected %h", act, prev);
                  end
               end
               prev      = act;
               have_prev = 1'b1;
            end
         end else begin
            have_prev = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   localparam logic [6:0] S12 = TRACE_SIZE_V12;
   localparam logic [6:0] S11 = TRACE_SIZE_V11;

   initial begin
      rst           = 1'b1;
      stats_clr     = 1'b0;
      stall_seen    = 1'b0;
      tif.in_valid  = 1'b0;
      tif.in_data   = '0;
      tif.in_size   = '0;
      tif.out_ready = 1'b1;

      // Reset state.
      #2;
      chk64("rst_out_valid", 64'(tif.out_valid), 64'd0);
      chk64("rst_rec_count", 64'(rec_count), 64'd0);
      chk64("rst_err_count", 64'(err_count), 64'd0);
      #10;
      rst = 1'b0;
      tick(1);

      // Single v1.2 record: 2-cycle latency, latency 30, residual 2.
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd0, 64'd100, 64'd130,
              32'd5, 32'd15, 32'd6, 32'd2), S12, 1'b1, 1'b0);
      @(negedge clk);
      chk64("t1_valid_early", 64'(tif.out_valid), 64'd0);
      @(negedge clk);
      chk64("t1_valid_n2", 64'(tif.out_valid), 64'd1);
      chk64("t1_latency", tif.out_latency, 64'd30);
      chk64("t1_residual", tif.out_residual, 64'd2);
      chk64("t1_has_attr", 64'(tif.out_has_attr), 64'd1);
      chk64("t1_rec_count", 64'(rec_count), 64'd1);
      tick(3);

      // Back-to-back 0,1,2,5 at full rate: gap of 2 on seq 5.
      clr_stats();
      stall_seen = 1'b0;
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd0, 64'd10, 64'd20, 32'd1, 32'd1, 32'd1, 32'd1), S12, 1'b1, 1'b0);
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd1, 64'd10, 64'd21, 32'd1, 32'd1, 32'd1, 32'd1), S12, 1'b1, 1'b0);
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd2, 64'd10, 64'd22, 32'd1, 32'd1, 32'd1, 32'd1), S12, 1'b1, 1'b0);
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd5, 64'd10, 64'd25, 32'd1, 32'd1, 32'd1, 32'd1), S12, 1'b1, 1'b1);
      chk64("t2_no_stall", 64'(stall_seen), 64'd0);
      tick(4);
      chk64("t2_gap_count", 64'(gap_count), 64'd2);
      chk64("t2_rec_count", 64'(rec_count), 64'd4);

      // Seq 10 after 5 is a gap of 4; then re-sync and run across the wrap.
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd10, 64'd0, 64'd9, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b1, 1'b1);
      tick(3);
      chk64("t3_gap_count_pre", 64'(gap_count), 64'd6);
      clr_stats();
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'hFFFF_FFFF, 64'd0, 64'd9, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b1, 1'b0);
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'h0000_0000, 64'd0, 64'd9, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b1, 1'b0);
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'h0000_0001, 64'd0, 64'd9, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b1, 1'b0);
      tick(3);
      chk64("t3_wrap_gap_count", 64'(gap_count), 64'd0);
      chk64("t3_wrap_reorder", 64'(reorder_count), 64'd0);
      // 3 (gap of 1), 2 (backward), 4 (in order: expected stayed 4).
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd3, 64'd0, 64'd9, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b1, 1'b1);
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd2, 64'd0, 64'd9, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b1, 1'b0);
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd4, 64'd0, 64'd9, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b1, 1'b0);
      tick(3);
      chk64("t3_reorder_count", 64'(reorder_count), 64'd1);
      chk64("t3_gap_count", 64'(gap_count), 64'd1);
      chk64("t3_rec_count", 64'(rec_count), 64'd6);

      // Bad headers: dropped, counted, sequence state untouched.
      send(mk(TRACE_VER_V11, REC_TX_EVENT, 1'b1, 32'd50, 64'd0, 64'd9, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b0, 1'b0);
      send(mk(TRACE_VER_V12, REC_MARKER,   1'b1, 32'd51, 64'd0, 64'd9, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b0, 1'b0);
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b0, 32'd52, 64'd0, 64'd9, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b0, 1'b0);
      tick(3);
      chk64("t4_err_count", 64'(err_count), 64'd3);
      chk64("t4_rec_count", 64'(rec_count), 64'd6);
      // v1.1 with garbage attribution bytes and wrapping timestamps: latency 0x20, residual 0x20.
      send(mk(TRACE_VER_V11, REC_TX_EVENT, 1'b1, 32'd5, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10,
              32'd7, 32'd7, 32'd7, 32'd7), S11, 1'b1, 1'b0);
      // Attribution 16 exceeds latency 10: attr_over, residual wraps to -6.
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd6, 64'd1000, 64'd1010,
              32'd4, 32'd4, 32'd4, 32'd4), S12, 1'b1, 1'b0);
      tick(3);
      chk64("t4_rec_count_after", 64'(rec_count), 64'd8);
      chk64("t4_gap_count", 64'(gap_count), 64'd1);

      // Backpressure for 5 cycles while 4 records stream.
      fork
         begin
            send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd7,  64'd0, 64'd70, 32'd1, 32'd2, 32'd3, 32'd4), S12, 1'b1, 1'b0);
            send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd8,  64'd0, 64'd80, 32'd1, 32'd2, 32'd3, 32'd4), S12, 1'b1, 1'b0);
            send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd9,  64'd0, 64'd90, 32'd1, 32'd2, 32'd3, 32'd4), S12, 1'b1, 1'b0);
            send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd10, 64'd0, 64'd99, 32'd1, 32'd2, 32'd3, 32'd4), S12, 1'b1, 1'b0);
         end
         begin
            tif.out_ready = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk64("t5_in_ready_full", 64'(tif.in_ready), 64'd0);
            chk64("t5_out_valid_held", 64'(tif.out_valid), 64'd1);
            repeat (3) @(posedge clk);
            #1;
            tif.out_ready = 1'b1;
         end
      join
      tick(6);
      chk64("t5_rec_count", 64'(rec_count), 64'd12);
      chk64("t5_queue_drained", 64'(exp_q.size()), 64'd0);

      // Reset with both stages full; then a fresh record takes the INIT path.
      tif.out_ready = 1'b0;
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd11, 64'd0, 64'd5, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b1, 1'b0);
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd12, 64'd0, 64'd5, 32'd0, 32'd0, 32'd0, 32'd0), S12, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk64("t6_rst_out_valid", 64'(tif.out_valid), 64'd0);
      chk64("t6_rst_rec_count", 64'(rec_count), 64'd0);
      chk64("t6_rst_err_count", 64'(err_count), 64'd0);
      chk64("t6_rst_gap_count", 64'(gap_count), 64'd0);
      chk64("t6_rst_reorder", 64'(reorder_count), 64'd0);
      exp_q.delete();
      tif.out_ready = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      tick(1);
      send(mk(TRACE_VER_V12, REC_TX_EVENT, 1'b1, 32'd77, 64'd0, 64'd50, 32'd10, 32'd10, 32'd10, 32'd10), S12, 1'b1, 1'b0);
      tick(4);
      chk64("t6_rec_count", 64'(rec_count), 64'd1);
      chk64("t6_gap_count", 64'(gap_count), 64'd0);
      chk64("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
